// File: rtl/fht_but_pipe_if.sv
// fht_but_pipe_if: operand/result bundle for the FHT butterfly pipeline.
//   master : upstream driver (address/coefficient generator side); drives operands, reads results
//   slave  : the butterfly itself
// Signals:
//   iEN        pipeline enable (0 freezes all state)
//   iVALID     operand sample valid
//   iSEL       bypass select (P = X1 * 1.0)
//   iX_0..2    signed operands, D_BIT wide
//   iSIN/iCOS  signed Q(W_BIT-2) coefficients
//   iOVF_CLR   clear for the sticky overflow flag
//   oVALID     result valid
//   oY_0/oY_1  sum / difference results, D_BIT wide
//   oOVF       sticky saturation flag
interface fht_but_pipe_if #(
  parameter int unsigned D_BIT = 17,
  parameter int unsigned W_BIT = 12
);
  logic                    iEN;
  logic                    iVALID;
  logic                    iSEL;
  logic signed [D_BIT-1:0] iX_0;
  logic signed [D_BIT-1:0] iX_1;
  logic signed [D_BIT-1:0] iX_2;
  logic signed [W_BIT-1:0] iSIN;
  logic signed [W_BIT-1:0] iCOS;
  logic                    iOVF_CLR;
  logic                    oVALID;
  logic signed [D_BIT-1:0] oY_0;
  logic signed [D_BIT-1:0] oY_1;
  logic                    oOVF;

  modport master (
    output iEN, iVALID, iSEL, iX_0, iX_1, iX_2, iSIN, iCOS, iOVF_CLR,
    input  oVALID, oY_0, oY_1, oOVF
  );

  modport slave (
    input  iEN, iVALID, iSEL, iX_0, iX_1, iX_2, iSIN, iCOS, iOVF_CLR,
    output oVALID, oY_0, oY_1, oOVF
  );
endinterface

// File: rtl/fht_but_pipe.sv
// fht_but_pipe: stallable three-stage radix-2 Hartley butterfly.
//   Y0 = (X0 + P) / 2^(F+SCALE), Y1 = (X0 - P) / 2^(F+SCALE), P = X1*cos + X2*sin,
//   F = W_BIT-2, results rounded then saturated to D_BIT signed.
// Ports:
//   iCLK    clock
//   iRESET  synchronous active-high reset (overrides bus.iEN)
//   bus     fht_but_pipe_if slave modport (operands, coefficients, flow control, results)
// Build option:
//   ROUND_FHT_EN  defined: round half away from zero; undefined: truncate toward -inf.
module fht_but_pipe #(
  parameter int unsigned D_BIT = 17,
  parameter int unsigned W_BIT = 12,
  parameter int unsigned SCALE = 1
) (
  input logic           iCLK,
  input logic           iRESET,
  fht_but_pipe_if.slave bus
);

  localparam int unsigned F  = W_BIT - 2;
  localparam int unsigned MW = D_BIT + W_BIT;  // product width
  localparam int unsigned PW = MW + 1;         // P width
  localparam int unsigned SW = MW + 2;         // sum/difference width
  localparam int unsigned K  = F + SCALE;      // total right shift at stage 3

  // Stage 1
  logic signed [MW-1:0] m0_d, m0_q;
  logic signed [MW-1:0] m1_d, m1_q;
  logic signed [MW-1:0] x0e1_d, x0e1_q;
  logic                 v1_d, v1_q;

  // Stage 2
  logic signed [PW-1:0] p_d, p_q;
  logic signed [MW-1:0] x0e2_d, x0e2_q;
  logic                 v2_d, v2_q;

  // Stage 3 / outputs
  logic signed [SW-1:0]    s_sum, s_dif;
  logic signed [D_BIT-1:0] y0_sat, y1_sat;
  logic                    clamp0, clamp1;
  logic signed [D_BIT-1:0] y0_d, y0_q;
  logic signed [D_BIT-1:0] y1_d, y1_q;
  logic                    v3_d, v3_q;
  logic                    ovf_d, ovf_q;

  // Scale by 2^-K, round, then clamp. Returns {clamped, result}.
  function automatic logic [D_BIT:0] scale_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] q;
    logic signed [SW-1:0] y_max;
    logic signed [SW-1:0] y_min;
    logic                 clamped;
`ifdef ROUND_FHT_EN
    logic signed [SW-1:0] mag;
    // Round the magnitude and restore the sign, giving half-away-from-zero.
    mag = v[SW-1] ? -v : v;
    q   = (mag + (SW'(1) <<< (K - 1))) >>> K;
    if (v[SW-1]) q = -q;
`else
    q = v >>> K;
`endif
    y_max   = (SW'(1) <<< (D_BIT - 1)) - SW'(1);
    y_min   = ~y_max;
    clamped = 1'b0;
    if (q > y_max) begin
      q       = y_max;
      clamped = 1'b1;
    end else if (q < y_min) begin
      q       = y_min;
      clamped = 1'b1;
    end
    return {clamped, q[D_BIT-1:0]};
  endfunction

  // Bypass is resolved here, so the mode travels with the sample inside m0/m1.
  always_comb begin
    m0_d   = m0_q;
    m1_d   = m1_q;
    x0e1_d = x0e1_q;
    v1_d   = v1_q;
    if (bus.iEN) begin
      x0e1_d = MW'(bus.iX_0) <<< F;
      v1_d   = bus.iVALID;
      if (bus.iSEL) begin
        m0_d = MW'(bus.iX_1) <<< F;
        m1_d = '0;
      end else begin
        m0_d = MW'(bus.iX_1) * MW'(bus.iCOS);
        m1_d = MW'(bus.iX_2) * MW'(bus.iSIN);
      end
    end
  end

  always_comb begin
    p_d    = p_q;
    x0e2_d = x0e2_q;
    v2_d   = v2_q;
    if (bus.iEN) begin
      p_d    = PW'(m0_q) + PW'(m1_q);
      x0e2_d = x0e1_q;
      v2_d   = v1_q;
    end
  end

  always_comb begin
    s_sum            = SW'(x0e2_q) + SW'(p_q);
    s_dif            = SW'(x0e2_q) - SW'(p_q);
    {clamp0, y0_sat} = scale_sat(s_sum);
    {clamp1, y1_sat} = scale_sat(s_dif);

    y0_d = y0_q;
    y1_d = y1_q;
    v3_d = v3_q;
    if (bus.iEN) begin
      y0_d = y0_sat;
      y1_d = y1_sat;
      v3_d = v2_q;
    end

    // Clear first so a coincident set wins; only valid samples can set.
    ovf_d = ovf_q;
    if (bus.iOVF_CLR) ovf_d = 1'b0;
    if (bus.iEN && v2_q && (clamp0 || clamp1)) ovf_d = 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      m0_d_rst: begin
        m0_q   <= '0;
        m1_q   <= '0;
        x0e1_q <= '0;
        v1_q   <= 1'b0;
        p_q    <= '0;
        x0e2_q <= '0;
        v2_q   <= 1'b0;
        y0_q   <= '0;
        y1_q   <= '0;
        v3_q   <= 1'b0;
        ovf_q  <= 1'b0;
      end
    end else begin
      m0_q   <= m0_d;
      m1_q   <= m1_d;
      x0e1_q <= x0e1_d;
      v1_q   <= v1_d;
      p_q    <= p_d;
      x0e2_q <= x0e2_d;
      v2_q   <= v2_d;
      y0_q   <= y0_d;
      y1_q   <= y1_d;
      v3_q   <= v3_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.oVALID = v3_q;
  assign bus.oY_0   = y0_q;
  assign bus.oY_1   = y1_q;
  assign bus.oOVF   = ovf_q;

endmodule

// File: tb/tb_fht_but_pipe.sv
// tb_fht_but_pipe: drives a SCALE=1 and a SCALE=0 butterfly with identical stimulus and checks
// every output after every clock against an arithmetic reference model.
module tb_fht_but_pipe;

  localparam int DB   = 17;
  localparam int WB   = 12;
  localparam int FQ   = WB - 2;
  localparam int ONE  = 1 << FQ;

  logic clk;
  logic rst;

  fht_but_pipe_if #(.D_BIT(DB), .W_BIT(WB)) bus1 ();
  fht_but_pipe_if #(.D_BIT(DB), .W_BIT(WB)) bus0 ();

  fht_but_pipe #(.D_BIT(DB), .W_BIT(WB), .SCALE(1)) u_dut_s1 (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus1)
  );

  fht_but_pipe #(.D_BIT(DB), .W_BIT(WB), .SCALE(0)) u_dut_s0 (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_vec;
  int    n_err;
  string phase;

  // Reference pipeline: index 0 = just sampled, index 2 = visible at outputs. [sc] = SCALE.
  bit    mv  [2][3];
  bit    mc  [2][3];
  longint my0[2][3];
  longint my1[2][3];
  bit    movf[2];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%s]: got %0d, expected %0d", tag, phase, got, exp);
    end
  endtask

  function automatic longint ref_div(input longint v, input int k);
    longint p2;
    longint m;
    p2 = longint'(1) << k;
`ifdef ROUND_FHT_EN
    m = (v < 0) ? -v : v;
    m = (m + p2 / 2) / p2;
    return (v < 0) ? -m : m;
`else
    if (v >= 0) return v / p2;
    return -((-v + p2 - 1) / p2);
`endif
  endfunction

  function automatic longint ref_clamp(input longint v, output bit c);
    longint hi;
    hi = (longint'(1) << (DB - 1)) - 1;
    c  = 1'b0;
    if (v > hi) begin c = 1'b1; return hi; end
    if (v < -hi - 1) begin c = 1'b1; return -hi - 1; end
    return v;
  endfunction

  task automatic ref_update(input bit r, input bit en, input bit vld, input bit sel,
                            input bit clr, input int x0, input int x1, input int x2,
                            input int c, input int s);
    longint p, vs, vd, y0, y1;
    bit     c0, c1;
    for (int sc = 0; sc < 2; sc++) begin
      if (r) begin
        for (int i = 0; i < 3; i++) begin
          mv[sc][i] = 0; mc[sc][i] = 0; my0[sc][i] = 0; my1[sc][i] = 0;
        end
        movf[sc] = 0;
      end else begin
        if (clr) movf[sc] = 0;
        if (en) begin
          if (mv[sc][1] && mc[sc][1]) movf[sc] = 1;
          p  = sel ? longint'(x1) * ONE : longint'(x1) * c + longint'(x2) * s;
          vs = longint'(x0) * ONE + p;
          vd = longint'(x0) * ONE - p;
          y0 = ref_clamp(ref_div(vs, FQ + sc), c0);
          y1 = ref_clamp(ref_div(vd, FQ + sc), c1);
          for (int i = 2; i > 0; i--) begin
            mv[sc][i] = mv[sc][i-1]; mc[sc][i] = mc[sc][i-1];
            my0[sc][i] = my0[sc][i-1]; my1[sc][i] = my1[sc][i-1];
          end
          mv[sc][0] = vld; mc[sc][0] = c0 | c1; my0[sc][0] = y0; my1[sc][0] = y1;
        end
      end
    end
  endtask

  // Apply one cycle of stimulus to both DUTs, clock it, then check all outputs.
  task automatic step(input bit r, input bit en, input bit vld, input bit sel, input bit clr,
                      input int x0, input int x1, input int x2, input int c, input int s);
    rst = r;
    bus1.iEN = en;  bus1.iVALID = vld; bus1.iSEL = sel; bus1.iOVF_CLR = clr;
    bus1.iX_0 = DB'(x0); bus1.iX_1 = DB'(x1); bus1.iX_2 = DB'(x2);
    bus1.iCOS = WB'(c);  bus1.iSIN = WB'(s);
    bus0.iEN = en;  bus0.iVALID = vld; bus0.iSEL = sel; bus0.iOVF_CLR = clr;
    bus0.iX_0 = DB'(x0); bus0.iX_1 = DB'(x1); bus0.iX_2 = DB'(x2);
    bus0.iCOS = WB'(c);  bus0.iSIN = WB'(s);
    @(posedge clk);
    ref_update(r, en, vld, sel, clr, x0, x1, x2, c, s);
    #1;
    check_eq("s1_valid", longint'(bus1.oVALID), longint'(mv[1][2]));
    check_eq("s1_y0",    longint'(bus1.oY_0),   my0[1][2]);
    check_eq("s1_y1",    longint'(bus1.oY_1),   my1[1][2]);
    check_eq("s1_ovf",   longint'(bus1.oOVF),   longint'(movf[1]));
    check_eq("s0_valid", longint'(bus0.oVALID), longint'(mv[0][2]));
    check_eq("s0_y0",    longint'(bus0.oY_0),   my0[0][2]);
    check_eq("s0_y1",    longint'(bus0.oY_1),   my1[0][2]);
    check_eq("s0_ovf",   longint'(bus0.oOVF),   longint'(movf[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    phase = "reset";
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_valid", longint'(bus1.oVALID), 0);
    check_eq("rst_y0", longint'(bus1.oY_0), 0);

    phase = "basic";
    step(0, 1, 1, 0, 0, 100, 50, 0, 1024, 0);
    idle(2);
    check_eq("basic_valid", longint'(bus1.oVALID), 1);
    check_eq("basic_y0", longint'(bus1.oY_0), 75);
    check_eq("basic_y1", longint'(bus1.oY_1), 25);
    check_eq("basic_ovf", longint'(bus1.oOVF), 0);

    phase = "round";
    step(0, 1, 1, 0, 0, 3, 0, 0, 1024, 0);
    idle(2);
`ifdef ROUND_FHT_EN
    check_eq("round_y0", longint'(bus1.oY_0), 2);
    check_eq("round_y1", longint'(bus1.oY_1), 2);
`else
    check_eq("round_y0", longint'(bus1.oY_0), 1);
    check_eq("round_y1", longint'(bus1.oY_1), 1);
`endif

    phase = "bypass";
    step(0, 1, 1, 1, 0, 100, 20, 5, 777, -300);
    idle(2);
    check_eq("bypass_y0", longint'(bus1.oY_0), 60);
    check_eq("bypass_y1", longint'(bus1.oY_1), 40);

    phase = "saturate";
    step(0, 1, 1, 0, 0, 65535, 65535, 0, 1024, 0);
    idle(2);
    check_eq("sat_y0", longint'(bus0.oY_0), 65535);
    check_eq("sat_y1", longint'(bus0.oY_1), 0);
    check_eq("sat_ovf", longint'(bus0.oOVF), 1);
    idle(3);
    check_eq("sat_sticky", longint'(bus0.oOVF), 1);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    check_eq("sat_clr", longint'(bus0.oOVF), 0);
    // Clamp sample reaches the output on the same edge as the clear.
    step(0, 1, 1, 0, 0, 65535, 65535, 0, 1024, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    check_eq("sat_clr_set", longint'(bus0.oOVF), 1);
    // Coefficient above 1.0 saturates the SCALE=1 instance too.
    step(0, 1, 1, 0, 0, -65536, -65536, -65536, 2047, 2047);
    idle(2);
    check_eq("sat1_y0", longint'(bus1.oY_0), -65536);
    check_eq("sat1_ovf", longint'(bus1.oOVF), 1);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    // An invalid clamping sample must not set the flag.
    step(0, 1, 0, 0, 0, 65535, 65535, 0, 1024, 0);
    idle(3);
    check_eq("inv_noovf", longint'(bus0.oOVF), 0);

    phase = "stall";
    step(0, 1, 1, 0, 0, 1000, 300, -200, 900, 400);
    step(0, 1, 1, 1, 0, -700, 250, 11, 5, 6);
    step(0, 0, 1, 0, 0, 9999, 9999, 9999, 2000, 2000);
    step(0, 0, 1, 0, 1, 9999, 9999, 9999, 2000, 2000);
    step(0, 1, 1, 0, 0, 12345, -4321, 777, -1500, 333);
    step(0, 1, 1, 1, 0, -1, 1, 0, 0, 0);
    idle(4);

    phase = "reset_mid";
    step(0, 1, 1, 0, 0, 500, 500, 500, 1024, 1024);
    step(0, 1, 1, 0, 0, 600, 600, 600, 1024, 1024);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rmid_valid", longint'(bus1.oVALID), 0);
    check_eq("rmid_y0", longint'(bus1.oY_0), 0);
    idle(4);

    phase = "random";
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
           int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 4095)) - 2048,
           int'($urandom_range(0, 4095)) - 2048);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
